// File: rtl/mmss_timer_if.sv
// mmss_timer_if: control pulses in, mm:ss value and status levels out, for the timer core.
// Latency: none (wiring only); timing is set by the core that drives the outputs.
// Backpressure: none; inputs are single-cycle pulses or levels, outputs are levels.
interface mmss_timer_if #(
  parameter int MIN_W = 7
);
  // Control pulses from the debounce wrapper. mode is a level.
  logic             start;
  logic             stop;
  logic             clear;
  logic             inc_min;
  logic             inc_sec;
  logic             mode;

  // Value and status toward the display driver and blink stage.
  logic [MIN_W-1:0] minutes;
  logic [5:0]       seconds;
  logic             running;
  logic             expired;
  logic             alarm;
  logic             blink;

  // Pulse source side (debounce wrapper or bench).
  modport master (
    output start, stop, clear, inc_min, inc_sec, mode,
    input  minutes, seconds, running, expired, alarm, blink
  );

  // Timer core side.
  modport slave (
    input  start, stop, clear, inc_min, inc_sec, mode,
    output minutes, seconds, running, expired, alarm, blink
  );
endinterface

// File: rtl/mmss_timer_core.sv
// mmss_timer_core: mm:ss countdown / count-up timer with prescaler, pause, alarm and blink.
// Latency: one clk from an accepted pulse or internal tick to the registered outputs.
// Backpressure: none; a pulse that loses same-cycle priority or is not legal in the state is dropped.
module mmss_timer_core #(
  parameter int TICK_DIV  = 100_000_000,
  parameter int BLINK_DIV = 50_000_000,
  parameter int MAX_MIN   = 99,
  parameter int MIN_W     = 7
) (
  input  logic        clk,
  input  logic        rst,
  mmss_timer_if.slave bus
);

  // MAX_MIN must fit in MIN_W bits and be at least 1.
  localparam int PRESC_W = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [MIN_W-1:0]   MIN_MAX    = MIN_W'(MAX_MIN);
  localparam logic [MIN_W-1:0]   MIN_ONE    = MIN_W'(1);
  localparam logic [5:0]         SEC_MAX    = 6'd59;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  // Displayed time value kept as one packed word so terminal compares are single compares.
  typedef struct packed {
    logic [MIN_W-1:0] mins;
    logic [5:0]       secs;
  } mmss_t;

  localparam mmss_t VAL_ZERO = '0;
  localparam mmss_t VAL_TOP  = '{mins: MIN_MAX, secs: SEC_MAX};

  state_t             state_q, state_d;
  mmss_t              val_q, val_d;
  mmss_t              val_dec, val_inc;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               mode_q, mode_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_q, blink_d;
  logic               alarm_q, alarm_d;
  logic               running_q, expired_q;

  logic               tick;
  logic               val_is_zero;
  logic               val_is_top;
  logic               start_from_idle;

  assign tick            = (state_q == RUN) && (presc_q == PRESC_LAST);
  assign val_is_zero     = (val_q == VAL_ZERO);
  assign val_is_top      = (val_q == VAL_TOP);
  // A countdown cannot start from 00:00; a count-up can.
  assign start_from_idle = bus.start && (state_q == IDLE) && !(!bus.mode && val_is_zero);

  // One-second step of the value in each direction (countdown borrows, count-up carries).
  always_comb begin
    val_dec = val_q;
    val_inc = val_q;
    if (val_q.secs != 6'd0) begin
      val_dec.secs = val_q.secs - 6'd1;
    end else begin
      val_dec.mins = val_q.mins - MIN_ONE;
      val_dec.secs = SEC_MAX;
    end
    if (val_q.secs == SEC_MAX) begin
      val_inc.mins = val_q.mins + MIN_ONE;
      val_inc.secs = 6'd0;
    end else begin
      val_inc.secs = val_q.secs + 6'd1;
    end
  end

  // Next state, value, prescaler and latched mode; events in priority order, only one acts.
  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    presc_d = presc_q;
    mode_d  = mode_q;

    if (bus.clear) begin
      state_d = IDLE;
      val_d   = VAL_ZERO;
      presc_d = '0;
    end else if (bus.stop && (state_q == RUN)) begin
      // Pausing holds the prescaler, even when this cycle was a tick.
      state_d = PAUSE;
    end else if (start_from_idle) begin
      state_d = RUN;
      mode_d  = bus.mode;
      presc_d = '0;
    end else if (bus.start && (state_q == PAUSE)) begin
      // Resume keeps the partial second accumulated before the pause.
      state_d = RUN;
    end else if (state_q == RUN) begin
      // Increment pulses are never accepted while running.
      if (tick) begin
        presc_d = '0;
        if (!mode_q) begin
          // Value may already be 00:00 if it was wrapped there during a pause.
          if (val_is_zero) begin
            state_d = EXPIRED;
          end else begin
            val_d = val_dec;
            if (val_dec == VAL_ZERO) begin
              state_d = EXPIRED;
            end
          end
        end else begin
          // Saturate at the top value; it may already be there after pause edits.
          if (val_is_top) begin
            state_d = EXPIRED;
          end else begin
            val_d = val_inc;
            if (val_inc == VAL_TOP) begin
              state_d = EXPIRED;
            end
          end
        end
      end else begin
        presc_d = presc_q + PRESC_W'(1);
      end
    end else if (bus.inc_min && ((state_q == IDLE) || (state_q == PAUSE))) begin
      val_d.mins = (val_q.mins == MIN_MAX) ? '0 : (val_q.mins + MIN_ONE);
    end else if (bus.inc_sec && ((state_q == IDLE) || (state_q == PAUSE))) begin
      // Seconds wrap on their own with no carry into minutes.
      val_d.secs = (val_q.secs == SEC_MAX) ? 6'd0 : (val_q.secs + 6'd1);
    end
  end

  // Display enable: steady on in IDLE/RUN, dark-first blinking in PAUSE/EXPIRED.
  always_comb begin
    blink_cnt_d = '0;
    blink_d     = 1'b1;
    if (state_d != state_q) begin
      blink_d = (state_d == IDLE) || (state_d == RUN);
    end else if ((state_q == PAUSE) || (state_q == EXPIRED)) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_d = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        blink_d     = blink_q;
      end
    end
  end

  // Alarm fires only on the transition into EXPIRED, never while sitting there.
  always_comb begin
    alarm_d = (state_d == EXPIRED) && (state_q != EXPIRED);
  end

  // State and datapath registers; every output comes straight from one of these.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      val_q       <= VAL_ZERO;
      presc_q     <= '0;
      mode_q      <= 1'b0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b1;
      alarm_q     <= 1'b0;
      running_q   <= 1'b0;
      expired_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      val_q       <= val_d;
      presc_q     <= presc_d;
      mode_q      <= mode_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      alarm_q     <= alarm_d;
      running_q   <= (state_d == RUN);
      expired_q   <= (state_d == EXPIRED);
    end
  end

  assign bus.minutes = val_q.mins;
  assign bus.seconds = val_q.secs;
  assign bus.running = running_q;
  assign bus.expired = expired_q;
  assign bus.alarm   = alarm_q;
  assign bus.blink   = blink_q;

endmodule

// File: tb/tb_mmss_timer_core.sv
// tb_mmss_timer_core: directed bench for the mm:ss timer core at small divider settings.
// Latency: checks one clk after each driven edge, sampling #1 past the rising edge.
// Backpressure: none; pulses are driven for exactly one clk.
module tb_mmss_timer_core;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  mmss_timer_if #(.MIN_W(2)) bus ();

  mmss_timer_core #(
    .TICK_DIV (10),
    .BLINK_DIV(4),
    .MAX_MIN  (3),
    .MIN_W    (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_val(input string tag, input int m, input int s);
    chk({tag, "_min"}, 32'(bus.minutes), 32'(m));
    chk({tag, "_sec"}, 32'(bus.seconds), 32'(s));
  endtask

  task automatic chk_st(input string tag, input int run, input int exp_d, input int alm, input int blk);
    chk({tag, "_running"}, 32'(bus.running), 32'(run));
    chk({tag, "_expired"}, 32'(bus.expired), 32'(exp_d));
    chk({tag, "_alarm"},   32'(bus.alarm),   32'(alm));
    chk({tag, "_blink"},   32'(bus.blink),   32'(blk));
  endtask

  task automatic p_start();   bus.start   = 1'b1; step(); bus.start   = 1'b0; endtask
  task automatic p_stop();    bus.stop    = 1'b1; step(); bus.stop    = 1'b0; endtask
  task automatic p_clear();   bus.clear   = 1'b1; step(); bus.clear   = 1'b0; endtask
  task automatic p_inc_min(input int n = 1);
    for (int i = 0; i < n; i++) begin bus.inc_min = 1'b1; step(); bus.inc_min = 1'b0; end
  endtask
  task automatic p_inc_sec(input int n = 1);
    for (int i = 0; i < n; i++) begin bus.inc_sec = 1'b1; step(); bus.inc_sec = 1'b0; end
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.clear   = 1'b0;
    bus.inc_min = 1'b0;
    bus.inc_sec = 1'b0;
    bus.mode    = 1'b0;

    // 1. Reset values, then countdown start at 00:00 is ignored.
    step(2);
    rst = 1'b0;
    step();
    chk_val("rst", 0, 0);
    chk_st("rst", 0, 0, 0, 1);
    p_start();
    chk_val("start_zero", 0, 0);
    chk_st("start_zero", 0, 0, 0, 1);

    // 2. Countdown from 01:02 to alarm.
    p_inc_min(1);
    p_inc_sec(2);
    chk_val("load_0102", 1, 2);
    bus.mode = 1'b0;
    p_start();
    chk_val("cd_start", 1, 2);
    chk_st("cd_start", 1, 0, 0, 1);
    step(9);
    chk_val("cd_pre_tick", 1, 2);
    step(1);
    chk_val("cd_tick1", 1, 1);
    step(10);
    chk_val("cd_tick2", 1, 0);
    step(10);
    chk_val("cd_borrow", 0, 59);
    step(580);
    chk_val("cd_0001", 0, 1);
    step(9);
    chk_val("cd_0001_hold", 0, 1);
    chk("cd_not_expired", 32'(bus.expired), 32'd0);
    step(1);
    chk_val("cd_expire", 0, 0);
    chk_st("cd_expire", 0, 1, 1, 0);
    step(1);
    chk_st("cd_exp_p1", 0, 1, 0, 0);
    step(2);
    chk("cd_blink_p3", 32'(bus.blink), 32'd0);
    step(1);
    chk("cd_blink_p4", 32'(bus.blink), 32'd1);
    step(3);
    chk("cd_blink_p7", 32'(bus.blink), 32'd1);
    step(1);
    chk("cd_blink_p8", 32'(bus.blink), 32'd0);
    p_start();
    chk_val("exp_start", 0, 0);
    chk("exp_start_expired", 32'(bus.expired), 32'd1);
    chk("exp_start_running", 32'(bus.running), 32'd0);
    chk("exp_start_alarm", 32'(bus.alarm), 32'd0);
    p_stop();
    chk("exp_stop_expired", 32'(bus.expired), 32'd1);
    p_clear();
    chk_val("exp_clear", 0, 0);
    chk_st("exp_clear", 0, 0, 0, 1);

    // 3. Pause and resume from 00:05, stopping six cycles into a second.
    p_inc_sec(5);
    p_start();
    chk("pr_running", 32'(bus.running), 32'd1);
    step(6);
    p_stop();
    chk_val("pr_paused", 0, 5);
    chk_st("pr_paused", 0, 0, 0, 0);
    step(4);
    chk("pr_blink_p4", 32'(bus.blink), 32'd1);
    step(4);
    chk("pr_blink_p8", 32'(bus.blink), 32'd0);
    step(22);
    chk_val("pr_frozen", 0, 5);
    chk("pr_blink_p30", 32'(bus.blink), 32'd1);
    p_inc_sec(1);
    chk_val("pr_inc_sec", 0, 6);
    p_start();
    chk_st("pr_resume", 1, 0, 0, 1);
    step(3);
    chk_val("pr_resume_hold", 0, 6);
    step(1);
    chk_val("pr_resume_tick", 0, 5);
    p_clear();
    chk_val("pr_clear", 0, 0);

    // 4. Count-up saturation from 03:58 with mode toggled mid-run.
    p_inc_min(3);
    p_inc_sec(58);
    chk_val("cu_load", 3, 58);
    bus.mode = 1'b1;
    p_start();
    chk("cu_running", 32'(bus.running), 32'd1);
    bus.mode = 1'b0;
    step(9);
    chk_val("cu_pre_tick", 3, 58);
    step(1);
    chk_val("cu_sat", 3, 59);
    chk_st("cu_sat", 0, 1, 1, 0);
    step(1);
    chk("cu_alarm_once", 32'(bus.alarm), 32'd0);
    step(10);
    chk_val("cu_hold", 3, 59);
    chk("cu_alarm_quiet", 32'(bus.alarm), 32'd0);
    p_clear();
    chk_val("cu_clear", 0, 0);

    // 5. Wraps and same-cycle priority.
    p_inc_sec(59);
    chk_val("wr_0059", 0, 59);
    p_inc_sec(1);
    chk_val("wr_sec_wrap", 0, 0);
    p_inc_min(3);
    p_inc_sec(2);
    chk_val("wr_0302", 3, 2);
    p_inc_min(1);
    chk_val("wr_min_wrap", 0, 2);
    bus.mode = 1'b0;
    p_start();
    step(2);
    bus.stop  = 1'b1;
    bus.start = 1'b1;
    step();
    bus.stop  = 1'b0;
    bus.start = 1'b0;
    chk_st("pri_stop_start", 0, 0, 0, 0);
    chk_val("pri_stop_start", 0, 2);
    p_start();
    chk("pri_resume", 32'(bus.running), 32'd1);
    p_inc_min(1);
    chk_val("run_inc_min", 0, 2);
    p_inc_sec(1);
    chk_val("run_inc_sec", 0, 2);
    bus.clear = 1'b1;
    bus.start = 1'b1;
    step();
    bus.clear = 1'b0;
    bus.start = 1'b0;
    chk_val("pri_clear_start", 0, 0);
    chk_st("pri_clear_start", 0, 0, 0, 1);

    // 6. Asynchronous reset between clock edges during a count-up run.
    bus.mode = 1'b1;
    p_start();
    step(12);
    chk_val("ar_before", 0, 1);
    #3;
    rst = 1'b1;
    #1;
    chk_val("ar_async", 0, 0);
    chk_st("ar_async", 0, 0, 0, 1);
    #2;
    rst = 1'b0;
    step();
    p_start();
    chk("ar_restart_running", 32'(bus.running), 32'd1);
    step(9);
    chk_val("ar_restart_hold", 0, 0);
    step(1);
    chk_val("ar_restart_tick", 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mmss_timer_core.md
Name: mmss_timer_core

Overview:
- Parametrised minutes:seconds timer core with an internal 1 Hz-equivalent prescaler.
- Supports two modes, latched at start: countdown (mode=0) and stopwatch count-up (mode=1).
- Provides pause/resume, saturating terminal detection, a one-cycle alarm pulse, and a blink/display-enable output.
- Sits between the button debounce wrapper (single-cycle pulse inputs) and the display driver/blink stage.

Parameters:
- TICK_DIV, 100_000_000: clk cycles per timer second.
- BLINK_DIV, 50_000_000: clk cycles per blink half-period.
- MAX_MIN, 99: largest minutes value. Must satisfy MAX_MIN ≤ 2^MIN_W−1 and MAX_MIN ≥ 1.
- MIN_W, 7: width of the minutes output.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse: start or resume.
- stop  in  1  one-cycle pulse: pause.
- clear  in  1  one-cycle pulse: return to IDLE at 00:00.
- inc_min  in  1  one-cycle pulse: minutes +1 (wraps).
- inc_sec  in  1  one-cycle pulse: seconds +1 (wraps).
- mode  in  1  0 = countdown, 1 = count-up; sampled only on an accepted start from IDLE.
- minutes  out  MIN_W  current minutes value.
- seconds  out  6  current seconds value, 0..59.
- running  out  1  high while in RUN.
- expired  out  1  high while in EXPIRED.
- alarm  out  1  one-cycle pulse on entry to EXPIRED.
- blink  out  1  display enable; 1 = digits visible.

Behaviour:
- Reset is asynchronous, active-high. Reset values:
  - state = IDLE, minutes = 0, seconds = 0.
  - running = 0, expired = 0, alarm = 0, blink = 1.
  - Prescaler = 0, blink counter = 0, latched mode = 0.
- All outputs are registered.
- States and transitions:
  - IDLE → RUN on start. Not taken if latched mode would be countdown and the value is 00:00; start is ignored in that case.
  - RUN → PAUSE on stop.
  - PAUSE → RUN on start.
  - RUN → EXPIRED on terminal value.
  - Any state → IDLE on clear.
  - EXPIRED exits only via clear or rst; start and stop are ignored there.
- Same-cycle priority: clear > stop > start > tick > inc_min > inc_sec. Only the highest-priority applicable event acts.
- Prescaler:
  - Counts 0..TICK_DIV−1 only in RUN.
  - tick = RUN && prescaler == TICK_DIV−1.
  - Cleared on IDLE→RUN and on clear.
  - Held (not cleared) in PAUSE, so resume continues the partial second.
- Countdown tick:
  - If seconds > 0: seconds−1.
  - Else: minutes−1 and seconds = 59.
  - If the new value is 00:00, the same edge moves to EXPIRED.
- Count-up tick:
  - seconds+1; on 59, seconds = 0 and minutes+1.
  - If the new value is MAX_MIN:59, the same edge moves to EXPIRED. The value saturates there.
- The value update and the state change happen on the same clk edge as the tick. Latency from the tick cycle to the output change is 1 cycle.
- alarm is high for exactly the one cycle after the edge that enters EXPIRED. It does not re-fire until a new RUN reaches terminal.
- inc_min / inc_sec:
  - Accepted only in IDLE and PAUSE; ignored in RUN and EXPIRED.
  - inc_sec: 59 → 0, with no carry into minutes.
  - inc_min: MAX_MIN → 0.
- mode is latched on IDLE→RUN. Changes during RUN or PAUSE have no effect.
- blink:
  - 1 in IDLE and RUN.
  - In PAUSE and EXPIRED: 0 for BLINK_DIV cycles from entry, then toggles every BLINK_DIV cycles.
  - The blink counter is cleared on every state change.
- clear (any state): minutes = 0, seconds = 0, prescaler = 0, alarm = 0, blink = 1, next state IDLE.
- rst mid-operation: immediate return to reset values regardless of clk.
- A tick coinciding with stop: no value change in that cycle; the state goes to PAUSE.

Test Plan (TICK_DIV=10, BLINK_DIV=4, MAX_MIN=3, MIN_W=2):
1. Reset → minutes=0, seconds=0, running=0, expired=0, alarm=0, blink=1. Start in mode=0 at 00:00 → ignored; state stays IDLE.
2. Countdown to alarm:
   - Stimulus: inc_min×1, inc_sec×2 (01:02), then start in mode 0.
   - Every 10 cycles the value steps 01:01, 01:00, 00:59, …, 00:00.
   - On the 00:00 edge: expired=1, running=0. alarm is high for 1 cycle. blink pattern is 0,0,0,0,1,1,1,1,…
   - Further start/stop pulses → no change. clear → IDLE, 00:00, blink=1.
3. Pause/resume:
   - Stimulus: run countdown from 00:05; stop 6 cycles into a second; hold 30 cycles; start.
   - Value frozen during PAUSE and blink toggles. inc_sec in PAUSE adds 1.
   - After resume, the next tick arrives 4 cycles later.
4. Count-up saturation:
   - Stimulus: start in mode 1 from 03:58.
   - Next tick → 03:59, EXPIRED, alarm pulse; the value stays 03:59.
   - Toggling mode mid-run has no effect.
5. Wrap and priority:
   - inc_sec at 00:59 → 00:00 (no carry). inc_min at 03:xx → 00:xx.
   - stop and start in the same cycle in RUN → PAUSE.
   - clear with start in the same cycle → IDLE, 00:00.
   - inc pulses during RUN → ignored.
6. Async reset:
   - Assert rst mid-RUN between clk edges → outputs reach reset values before the next edge.
   - Deassert rst, then start in mode 1 → counts from 00:00.
